ram32x4_arbiter: RTL and testbench
==================================

# ram32x4_arbiter

Two-requester arbiter and sequencer for the 32x4 RAM (`ram32x4`). It lets two independent requesters (A and B) share the single RAM port. It serialises their accesses through a three-state FSM, drives the RAM's `clk`/`write`/`addr`/`din` and returns read data with a done pulse. It sits between the board-level top and `ram32x4`, which runs on the same clock as this block.

## Interface
Parameters:
- `AW`, 5: address width (32 words).
- `DW`, 4: data width.

Ports (`clk` and `rst_n` form the single clock/reset pair; reset is asynchronous, active-low):
- `clk`  input  1  system clock; also drives the RAM `clk`.
- `rst_n`  input  1  asynchronous active-low reset.
- `req_a`, `req_b`  input  1  access request, held until the matching grant.
- `we_a`, `we_b`  input  1  1 = write, 0 = read; sampled with the request.
- `addr_a`, `addr_b`  input  AW  word address.
- `din_a`, `din_b`  input  DW  write data.
- `gnt_a`, `gnt_b`  output  1  one-cycle grant pulse.
- `done_a`, `done_b`  output  1  one-cycle completion pulse; `rdata` is valid in that cycle.
- `rdata`  output  DW  data captured from the RAM.
- `ram_write`  output  1  to RAM `write`.
- `ram_addr`  output  AW  to RAM `addr`.
- `ram_din`  output  DW  to RAM `din`.
- `ram_dout`  input  DW  from RAM `dout`; combinational read of `ram_addr`.

## Operation
- FSM states and transitions:
  - IDLE → ACCESS when any `req_*` is sampled high.
  - ACCESS → DONE unconditionally.
  - DONE → IDLE unconditionally.
- Requests are ignored in ACCESS and DONE. The FSM never goes DONE→ACCESS directly.
- Arbitration happens in IDLE only.
  - One request high: that requester wins.
  - Both high: round-robin. The winner is the requester not granted last. The `last` register updates on every grant.
- On the IDLE→ACCESS edge, register the winner's `we`/`addr`/`din` into `ram_write`/`ram_addr`/`ram_din`.
- Set `gnt_<winner>` = 1 for the ACCESS cycle only.
- On the ACCESS→DONE edge:
  - Capture `ram_dout` into `rdata`.
  - Clear `ram_write`.
  - Set `done_<winner>` = 1 for the DONE cycle only.
- Write semantics are read-before-write: a write's `rdata` returns the pre-write contents of the addressed word.
- `ram_addr`/`ram_din` hold their last values outside ACCESS. `ram_write` = 1 only in ACCESS.
- Requester rule: hold `req`/`we`/`addr`/`din` stable until `gnt` is seen; `req` may drop in the cycle after `gnt`. A `req` still high in DONE is treated as a new request once the FSM is back in IDLE.
- `gnt_a` & `gnt_b` and `done_a` & `done_b` are never high together.

## Timing
- Reset (async assert, synchronous release): state = IDLE, `last` = B (so A wins the first tie), and every output is 0 (`gnt_*`, `done_*`, `rdata`, `ram_write`, `ram_addr`, `ram_din`).
- Request sampled at edge k: `gnt` is high during [k, k+1), the RAM write commits at edge k+1, and `done`/`rdata` are valid during [k+1, k+2).
- Earliest next grant is at edge k+3. Peak throughput is 1 access per 3 cycles.
- Continuous requests from both requesters alternate A, B, A, B….
- A reset asserted in ACCESS drops `ram_write` immediately (asynchronously). The RAM write at the next edge must not occur, and no `done` is issued.
- The read path is combinational inside the RAM. The ACCESS cycle must cover the RAM read delay.

## Configuration
- `ARB_FIXED_PRIO_EN`:
  - Defined: A always wins ties. The `last` register is removed, and B can starve while A requests continuously.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset: assert `rst_n`=0 mid-run → all outputs 0 and state IDLE within the same cycle; no `ram_write` pulse follows.
- Single write then read: A writes addr 5 = 0xA → `gnt_a` at k, `ram_write`=1 for 1 cycle, `done_a` at k+1. A then reads addr 5 → `rdata`=0xA with `done_a`.
- Read-before-write: word 3 holds 0x6; B writes 0x9 to addr 3 → `rdata`=0x6 at `done_b`; a subsequent read of addr 3 returns 0x9.
- Tie after reset: `req_a`=`req_b`=1 held → grant order A, B, A, B; grants 3 cycles apart; no overlapping `gnt`/`done` pulses.
- Boundary addresses: write 0xF to addr 0 and 0x1 to addr 31 → reads return 0xF and 0x1; other words unchanged.
- `ARB_FIXED_PRIO_EN` build, both requests held → every grant goes to A; `gnt_b` only after `req_a` drops.

Source files
------------

// File: rtl/ram32x4_arbiter.sv
// Two-requester arbiter/sequencer for ram32x4: IDLE->ACCESS->DONE, one access per 3 cycles, requests held until gnt.
// Define ARB_FIXED_PRIO_EN for fixed A-over-B priority; default is round-robin on ties.
module ram32x4_arbiter #(
    parameter int AW = 5,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          we_a,
    input  logic          we_b,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] din_a,
    input  logic [DW-1:0] din_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          done_a,
    output logic          done_b,
    output logic [DW-1:0] rdata,
    output logic          ram_write,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t state;
    state_t state_nxt;
    logic   grant;
    logic   pick_b;
    logic   cur_b;

`ifdef ARB_FIXED_PRIO_EN
    assign pick_b = req_b & ~req_a;
`else
    // last_b = 1 means B was granted most recently, so A wins the next tie
    logic last_b;

    assign pick_b = req_b & (~req_a | ~last_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b <= 1'b1;
        end else if (grant) begin
            last_b <= pick_b;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (req_a || req_b) begin
                    state_nxt = ACCESS;
                    grant     = 1'b1;
                end
            end
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            done_a    <= 1'b0;
            done_b    <= 1'b0;
            rdata     <= '0;
            ram_write <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            cur_b     <= 1'b0;
        end else begin
            gnt_a  <= 1'b0;
            gnt_b  <= 1'b0;
            done_a <= 1'b0;
            done_b <= 1'b0;
            if (grant) begin
                cur_b     <= pick_b;
                gnt_a     <= ~pick_b;
                gnt_b     <= pick_b;
                ram_write <= pick_b ? we_b   : we_a;
                ram_addr  <= pick_b ? addr_b : addr_a;
                ram_din   <= pick_b ? din_b  : din_a;
            end else if (state == ACCESS) begin
                // ram_dout still shows the old word here, giving read-before-write
                rdata     <= ram_dout;
                ram_write <= 1'b0;
                done_a    <= ~cur_b;
                done_b    <= cur_b;
            end
        end
    end

endmodule

// File: tb/tb_ram32x4_arbiter.sv
// Bench for ram32x4_arbiter with a behavioural 32x4 RAM and a done/rdata scoreboard.
module tb_ram32x4_arbiter;
    localparam int AW = 5;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_a = 1'b0, req_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [DW-1:0] din_a = '0, din_b = '0;
    logic          gnt_a, gnt_b, done_a, done_b, ram_write;
    logic [DW-1:0] rdata, ram_din, ram_dout;
    logic [AW-1:0] ram_addr;

    logic [DW-1:0] mem [32] = '{default: '0};

    ram32x4_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .din_a(din_a), .din_b(din_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
        .rdata(rdata), .ram_write(ram_write), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_din;
    end
    assign ram_dout = mem[ram_addr];

    typedef struct {
        logic          is_b;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [DW-1:0] exp;
    } vec_t;

    typedef struct {
        logic          is_b;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("gnt_exclusive", {31'd0, gnt_a & gnt_b}, 0);
            check("done_exclusive", {31'd0, done_a & done_b}, 0);
            if (done_a || done_b) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_who", {31'd0, done_b}, {31'd0, mon_e.is_b});
                    check("rdata", {28'd0, rdata}, {28'd0, mon_e.rdata});
                end
            end
        end
    end

    task automatic drive(input vec_t v, input logic on);
        if (v.is_b) begin
            req_b = on; we_b = v.we; addr_b = v.addr; din_b = v.din;
        end else begin
            req_a = on; we_a = v.we; addr_a = v.addr; din_a = v.din;
        end
    endtask

    // Issues one access; with push=0 it returns right after the grant (ACCESS cycle)
    task automatic run_access(input vec_t v, input bit push);
        int lat;
        bit got;
        lat = 0;
        got = 0;
        @(negedge clk);
        drive(v, 1'b1);
        for (int c = 1; c <= 10 && !got; c++) begin
            @(posedge clk);
            #1;
            if (gnt_a || gnt_b) begin
                got = 1;
                lat = c;
            end
        end
        if (!got) begin
            check("grant_timeout", 0, 1);
            drive(v, 1'b0);
            return;
        end
        check("gnt_who", {31'd0, gnt_b}, {31'd0, v.is_b});
        check("gnt_latency", lat, 1);
        check("ram_write", {31'd0, ram_write}, {31'd0, v.we});
        check("ram_addr", {27'd0, ram_addr}, {27'd0, v.addr});
        if (v.we) check("ram_din", {28'd0, ram_din}, {28'd0, v.din});
        if (push) sb.push_back('{v.is_b, v.exp});
        drive(v, 1'b0);
        if (push) begin
            @(posedge clk);
            #1;
            check("done_timing", {31'd0, v.is_b ? done_b : done_a}, 1);
            check("ram_write_clear", {31'd0, ram_write}, 0);
            @(posedge clk);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {14'd0, gnt_a, gnt_b, done_a, done_b, rdata, ram_write, ram_addr, ram_din};
    endfunction

    vec_t tbl[11];
    vec_t v;

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 5'd5,  4'hA, 4'h0};
        tbl[1]  = '{1'b0, 1'b0, 5'd5,  4'h0, 4'hA};
        tbl[2]  = '{1'b1, 1'b1, 5'd3,  4'h6, 4'h0};
        tbl[3]  = '{1'b1, 1'b1, 5'd3,  4'h9, 4'h6};
        tbl[4]  = '{1'b0, 1'b0, 5'd3,  4'h0, 4'h9};
        tbl[5]  = '{1'b0, 1'b1, 5'd0,  4'hF, 4'h0};
        tbl[6]  = '{1'b1, 1'b1, 5'd31, 4'h1, 4'h0};
        tbl[7]  = '{1'b1, 1'b0, 5'd0,  4'h0, 4'hF};
        tbl[8]  = '{1'b0, 1'b0, 5'd31, 4'h0, 4'h1};
        tbl[9]  = '{1'b1, 1'b0, 5'd5,  4'h0, 4'hA};
        tbl[10] = '{1'b0, 1'b0, 5'd3,  4'h0, 4'h9};

        #2 rst_n = 1'b0;
        #1 check("reset_outputs", all_outs(), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        foreach (tbl[i]) run_access(tbl[i], 1'b1);

        // Reset during ACCESS: write must be cancelled and no done issued
        v = '{1'b0, 1'b1, 5'd7, 4'h5, 4'h0};
        run_access(v, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("reset_async", all_outs(), 0);
        @(posedge clk);
        #1 check("reset_held", all_outs(), 0);
        @(negedge clk) rst_n = 1'b1;
        v = '{1'b0, 1'b0, 5'd7, 4'h0, 4'h0};
        run_access(v, 1'b1);

        // Tie from reset: both requesters held
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b0; addr_a = 5'd5;
        req_b = 1'b1; we_b = 1'b0; addr_b = 5'd3;
        for (int i = 0; i < 4; i++) begin
            int  c;
            bit  got;
            logic exp_b;
`ifdef ARB_FIXED_PRIO_EN
            exp_b = 1'b0;
`else
            exp_b = logic'(i % 2);
`endif
            got = 0;
            c = 0;
            while (!got && c < 10) begin
                @(posedge clk);
                #1;
                c++;
                if (gnt_a || gnt_b) got = 1;
            end
            if (!got) begin
                check("tie_grant_timeout", 0, 1);
                break;
            end
            check("tie_who", {31'd0, gnt_b}, {31'd0, exp_b});
            check("tie_spacing", c, (i == 0) ? 1 : 3);
            sb.push_back('{exp_b, exp_b ? 4'h9 : 4'hA});
        end
        req_a = 1'b0;
        req_b = 1'b0;

        repeat (4) @(posedge clk);
        #1 check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
